// File: rtl/leader_pkg.sv
// leader_pkg: shared widths, frame length and sync state encoding for the leader channel.
package leader_pkg;
  localparam int T_W = 5;
  localparam int L_W = 2;
  localparam int FRAME_LEN = 32;
  typedef enum logic {SEARCH = 1'b0, LOCK = 1'b1} state_e;
endpackage

// File: rtl/leader_generator.sv
// leader_generator: maps frame index t to its 2-bit leader symbol.
// The high bit walks a binary de Bruijn sequence of order 5, so any 5 consecutive symbols pin down the phase.
module leader_generator
  import leader_pkg::*;
(
  input  logic [T_W-1:0] t,
  output logic [L_W-1:0] l
);
  localparam logic [FRAME_LEN-1:0] DB_SEQ = 32'b00000100011001010011101011011111;
  assign l = {DB_SEQ[~t], t[0] ^ t[2]};
endmodule

// File: rtl/leader_sync.sv
// leader_sync: recovers and tracks the frame phase of a received leader symbol stream.
module leader_sync
  import leader_pkg::*;
#(
  parameter int unsigned CONFIRM_LEN = 8,
  parameter int unsigned ERR_LIMIT = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           sym_valid,
  input  logic [L_W-1:0] sym,
  output logic           locked,
  output logic [T_W-1:0] t_out,
  output logic           t_valid,
  output logic           sym_err
);
  state_e state_q, state_d;
  logic [T_W-1:0] p_q, p_d, t_out_q, t_out_d;
  logic [4:0] match_cnt_q, match_cnt_d;
  logic [2:0] err_cnt_q, err_cnt_d;
  logic locked_q, locked_d, t_valid_q, t_valid_d, sym_err_q, sym_err_d;
  logic [L_W-1:0] exp_sym;
  logic hit;
  leader_generator u_gen (.t(p_q), .l(exp_sym));
  assign hit = sym == exp_sym;
  always_comb begin
    state_d = state_q;
    p_d = p_q;
    match_cnt_d = match_cnt_q;
    err_cnt_d = err_cnt_q;
    locked_d = locked_q;
    t_out_d = t_out_q;
    t_valid_d = 1'b0;
    sym_err_d = 1'b0;
    if (sym_valid && state_q == SEARCH) begin
      p_d = hit ? p_q + T_W'(1) : p_q + T_W'(2);
      match_cnt_d = hit ? match_cnt_q + 5'd1 : 5'd0;
      if (hit && match_cnt_q + 5'd1 == 5'(CONFIRM_LEN)) begin
        state_d = LOCK;
        locked_d = 1'b1;
        t_out_d = p_q;
        err_cnt_d = 3'd0;
        match_cnt_d = 5'd0;
      end
    end else if (sym_valid) begin
      p_d = p_q + T_W'(1);
      t_out_d = p_q;
      t_valid_d = 1'b1;
      sym_err_d = !hit;
      err_cnt_d = hit ? 3'd0 : err_cnt_q + 3'd1;
      // the dropping symbol still reports its error but no longer a valid phase
      if (!hit && err_cnt_q + 3'd1 == 3'(ERR_LIMIT)) begin
        state_d = SEARCH;
        locked_d = 1'b0;
        match_cnt_d = 5'd0;
        err_cnt_d = 3'd0;
        t_valid_d = 1'b0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SEARCH;
      p_q <= '0;
      match_cnt_q <= '0;
      err_cnt_q <= '0;
      locked_q <= 1'b0;
      t_out_q <= '0;
      t_valid_q <= 1'b0;
      sym_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q <= p_d;
      match_cnt_q <= match_cnt_d;
      err_cnt_q <= err_cnt_d;
      locked_q <= locked_d;
      t_out_q <= t_out_d;
      t_valid_q <= t_valid_d;
      sym_err_q <= sym_err_d;
    end
  end
  assign locked = locked_q;
  assign t_out = t_out_q;
  assign t_valid = t_valid_q;
  assign sym_err = sym_err_q;
endmodule

// File: tb/tb_leader_sync.sv
// tb_leader_sync: drives leader streams into leader_sync and compares against a behavioural model.
module tb_leader_sync;
  localparam int CONFIRM_LEN = 8;
  localparam int ERR_LIMIT = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sym_valid = 1'b0;
  logic [1:0] sym = 2'd0;
  logic locked, t_valid, sym_err;
  logic [4:0] t_out;
  int tests = 0, fails = 0;
  int tt = 0, se_cnt = 0;
  int m_lock, m_p, m_mc, m_ec, m_t, m_tv, m_se;
  int n, n_model, n_ref, e0;

  leader_sync #(.CONFIRM_LEN(CONFIRM_LEN), .ERR_LIMIT(ERR_LIMIT)) dut (
    .clk(clk), .rst_n(rst_n), .sym_valid(sym_valid), .sym(sym),
    .locked(locked), .t_out(t_out), .t_valid(t_valid), .sym_err(sym_err)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] leader(input int t);
    logic [31:0] db;
    db = 32'b00000100011001010011101011011111;
    return {db[31-t], 1'(t[0] ^ t[2])};
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input bit rn, input bit v, input bit cor);
    logic [1:0] s;
    int sent;
    s = v ? (leader(tt) ^ {1'b0, cor}) : 2'($urandom);
    rst_n = rn;
    sym_valid = v;
    sym = s;
    sent = tt;
    if (!rn) begin
      m_lock = 0; m_p = 0; m_mc = 0; m_ec = 0; m_t = 0; m_tv = 0; m_se = 0;
    end else begin
      m_tv = 0;
      m_se = 0;
      if (v && m_lock == 0) begin
        if (s == leader(m_p)) begin
          m_mc++;
          if (m_mc == CONFIRM_LEN) begin
            m_lock = 1; m_t = m_p; m_mc = 0; m_ec = 0;
          end
          m_p = (m_p + 1) % 32;
        end else begin
          m_mc = 0;
          m_p = (m_p + 2) % 32;
        end
      end else if (v) begin
        m_tv = 1;
        if (s == leader(m_p)) m_ec = 0;
        else begin
          m_se = 1;
          m_ec++;
          if (m_ec == ERR_LIMIT) begin
            m_lock = 0; m_ec = 0; m_mc = 0; m_tv = 0;
          end
        end
        m_t = m_p;
        m_p = (m_p + 1) % 32;
      end
      if (v) tt = (tt + 1) % 32;
    end
    @(posedge clk);
    #1;
    chk("locked", int'(locked), m_lock);
    chk("t_out", int'(t_out), m_t);
    chk("t_valid", int'(t_valid), m_tv);
    chk("sym_err", int'(sym_err), m_se);
    if (t_valid) chk("t_phase", int'(t_out), sent);
    if (sym_err) se_cnt++;
    @(negedge clk);
  endtask

  task automatic acquire(input int gap, output int cnt, output int cnt_model);
    int k;
    cnt = 0;
    cnt_model = -1;
    k = 0;
    while (!locked && k < 1200) begin
      step(1'b1, (k % gap) == 0, 1'b0);
      if ((k % gap) == 0) cnt++;
      if (m_lock == 1 && cnt_model < 0) cnt_model = cnt;
      k++;
    end
    chk("acq_timeout", int'(locked), 1);
  endtask

  initial begin
    @(negedge clk);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'($urandom));
    tt = 13;
    acquire(1, n, n_ref);
    chk("acq_bound", int'(n <= 32 * CONFIRM_LEN + CONFIRM_LEN), 1);
    chk("acq_model", n, n_ref);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b0);
    e0 = se_cnt;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, i == 2 || i == 5);
    chk("tol_errs", se_cnt - e0, 2);
    chk("tol_lock", int'(locked), 1);
    e0 = se_cnt;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);
    chk("loss_errs", se_cnt - e0, 3);
    chk("loss_lock", int'(locked), 0);
    acquire(1, n, n_model);
    chk("relock_len", n, CONFIRM_LEN);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("rst_lock", int'(locked), 0);
    chk("rst_tout", int'(t_out), 0);
    acquire(1, n, n_model);
    chk("reacq_min", int'(n >= CONFIRM_LEN), 1);
    step(1'b0, 1'b0, 1'b0);
    tt = 13;
    acquire(3, n, n_model);
    chk("gap_acq", n, n_ref);
    for (int i = 0; i < 12; i++) step(1'b1, (i % 3) == 0, 1'b0);
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/leader_sync.md
Name: leader_sync

Overview:
- Receive-side counterpart of leader_generator.
- leader_generator maps a 5-bit frame index t to a 2-bit leader symbol l. leader_sync consumes a stream of 2-bit leader symbols and recovers the frame index (phase) of the stream.
- It locks on that phase, then tracks it symbol by symbol, and drops lock on repeated mismatches.
- It sits at the receive end of the leader channel. It feeds t_out to downstream frame-aligned logic.

Parameters:
- CONFIRM_LEN, 8: consecutive matching symbols required before lock is declared (legal range 1..31).
- ERR_LIMIT, 3: consecutive mismatches in LOCK that force return to SEARCH (legal range 1..7).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  synchronous reset, active-low.
- sym_valid  input  1  sym carries a new leader symbol this cycle.
- sym  input  2  received leader symbol.
- locked  output  1  phase lock established.
- t_out  output  5  frame index of the most recently accepted symbol; meaningful only while locked=1.
- t_valid  output  1  one-cycle pulse: t_out was updated by a symbol accepted while locked.
- sym_err  output  1  one-cycle pulse: a symbol accepted in LOCK mismatched the expected value.

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=SEARCH, phase p=0, match_cnt=0, err_cnt=0.
  - Outputs: locked=0, t_out=0, t_valid=0, sym_err=0.
  - Reset mid-operation discards lock and counters immediately.
- Expected symbol is leader(p), from the combinational leader_generator with t=p. All phase arithmetic is mod 32 (5-bit natural wrap, 31+1=0, 31+2=1).
- When sym_valid=0:
  - All state holds.
  - t_valid and sym_err are 0 the following cycle.
- Latency: all outputs are registered. Responses appear at the posedge that samples sym_valid=1, visible the next cycle.
- SEARCH, on each valid symbol:
  - Match (sym==leader(p)):
    - p<=p+1, match_cnt<=match_cnt+1.
    - If match_cnt+1==CONFIRM_LEN: state<=LOCK, locked<=1, t_out<=p (phase of the symbol just accepted), err_cnt<=0, match_cnt<=0.
  - Mismatch:
    - p<=p+2 (slips the phase hypothesis by one symbol), match_cnt<=0.
    - The slip guarantees all 32 offsets are tried.
  - t_valid=0 and sym_err=0 throughout SEARCH.
- LOCK, on each valid symbol (expected leader(p)):
  - In all cases: p<=p+1, t_out<=p, t_valid<=1.
  - Match: err_cnt<=0.
  - Mismatch:
    - sym_err<=1, err_cnt<=err_cnt+1.
    - If err_cnt+1==ERR_LIMIT: state<=SEARCH, locked<=0, match_cnt<=0, err_cnt<=0, t_valid<=0.
    - p continues to advance by 1.
- Lock drop rule: the symbol that causes the drop asserts sym_err=1, t_valid=0, locked=0 together.
- Ambiguity: if the leader table is not unique over CONFIRM_LEN symbols, lock occurs on the first consistent hypothesis. This is correct-by-definition; the bench checks consistency with the table.
- Worst-case acquisition on a clean stream: at most 32*CONFIRM_LEN + CONFIRM_LEN valid symbols.
- Counter widths:
  - match_cnt: 5 bits.
  - err_cnt: 3 bits.
- Counters never exceed their parameter value, so no saturation logic is needed.

Decomposition:
- Shared package leader_pkg holds:
  - T_W=5 (frame index width) and L_W=2 (symbol width).
  - FRAME_LEN=32.
  - State encoding: SEARCH=1'b0, LOCK=1'b1.
- Sub-module: reuse the existing leader_generator, instantiated unchanged with t=p, as the expected-symbol source.
- No other sub-modules.

Test Plan:
- Reset: hold rst_n=0 with sym_valid=1 and random sym for 5 cycles -> locked=0, t_out=0, t_valid=0, sym_err=0 throughout.
- Acquisition: clean stream sym=leader(t) starting at t=13, one symbol per cycle -> locked rises within 32*8+8 symbols. Once locked, t_out equals the phase of each accepted symbol and increments by 1 per symbol; 31 is followed by 0.
- Gapped stream: same stream as acquisition with sym_valid toggling 1,0,0,1,… -> state, p and t_out hold on sym_valid=0 cycles. Lock is reached after the same number of valid symbols as the gapless case.
- Error tolerance: after lock, corrupt 2 non-adjacent symbols (sym XOR 2'b01) -> sym_err pulses twice, locked stays 1, t_out unaffected.
- Lock loss: after lock, corrupt 3 consecutive symbols -> sym_err pulses 3 times, and locked=0 after the third. On the resumed clean stream, re-lock with correct t_out.
- Reset mid-lock: assert rst_n=0 for 1 cycle while locked -> next cycle locked=0, t_out=0. Re-acquisition on a clean stream requires at least CONFIRM_LEN=8 valid symbols.
